// File: rtl/shift_sequencer.sv
// ============================================================================
// Module   : shift_sequencer
// Brief    : Iterative 16-bit rotate/shift unit, one binary-weighted stage
//            (8,4,2,1) per clock, valid/ready on both sides.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  input  logic [3:0]  in_cnt,
  input  logic [1:0]  in_op,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        busy
);

  localparam logic [1:0] c_op_rol = 2'b00;
  localparam logic [1:0] c_op_sll = 2'b01;
  localparam logic [1:0] c_op_ror = 2'b10;
  localparam logic [1:0] c_op_srl = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_acc;
  logic [3:0]  r_cnt;
  logic [1:0]  r_op;
  logic [1:0]  r_stage;
  logic [15:0] r_out_data;
  logic [15:0] w_acc_nxt;

  // One stage of the datapath: shift/rotate a by 2^stage.
  function automatic logic [15:0] f_stage(input logic [15:0] a,
                                          input logic [1:0]  op,
                                          input logic [1:0]  stage);
    logic [4:0]  k;
    logic [31:0] dbl;
    logic [15:0] res;
    k   = 5'd1 << stage;
    dbl = {a, a};
    res = a;
    case (op)
      c_op_rol: begin
        dbl = dbl << k;
        res = dbl[31:16];
      end
      c_op_sll: res = a << k;
      c_op_ror: begin
        dbl = dbl >> k;
        res = dbl[15:0];
      end
      c_op_srl: res = a >> k;
      default:  res = a;
    endcase
    return res;
  endfunction

  always_comb begin
    w_acc_nxt = r_acc;
    if (r_cnt[r_stage]) begin
      w_acc_nxt = f_stage(r_acc, r_op, r_stage);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (in_valid) w_state_nxt = S_SHIFT;
      S_SHIFT: if (r_stage == 2'd0) w_state_nxt = S_DONE;
      S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc      <= 16'h0000;
      r_cnt      <= 4'h0;
      r_op       <= 2'b00;
      r_stage    <= 2'd0;
      r_out_data <= 16'h0000;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_acc   <= in_data;
            r_cnt   <= in_cnt;
            r_op    <= in_op;
            r_stage <= 2'd3;
          end
        end
        S_SHIFT: begin
          r_acc <= w_acc_nxt;
          // Result register only loads on the final stage, so partial values never show.
          if (r_stage == 2'd0) begin
            r_out_data <= w_acc_nxt;
          end else begin
            r_stage <= r_stage - 2'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state == S_SHIFT) || (r_state == S_DONE);
  assign out_data  = r_out_data;

endmodule

`default_nettype wire

// File: tb/tb_shift_sequencer.sv
// ============================================================================
// Module   : tb_shift_sequencer
// Brief    : Directed-vector bench for shift_sequencer with a cycle model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_shift_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = 16'h0000;
  logic [3:0]  in_cnt = 4'h0;
  logic [1:0]  in_op = 2'b00;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic        busy;

  int total = 0;
  int bad = 0;

  shift_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_cnt    (in_cnt),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Bit-by-bit placement of each source bit at its destination.
  function automatic logic [15:0] ref_op(input logic [15:0] d, input int c, input logic [1:0] op);
    logic [15:0] r;
    r = 16'h0000;
    for (int i = 0; i < 16; i++) begin
      case (op)
        2'b00: r[(i + c) % 16] = d[i];
        2'b01: if (i + c < 16) r[i + c] = d[i];
        2'b10: r[(i - c + 16) % 16] = d[i];
        default: if (i >= c) r[i - c] = d[i];
      endcase
    end
    return r;
  endfunction

  // Phase 0 idle, 1..4 shifting, 5 result waiting.
  int          m_phase = 0;
  logic [15:0] m_res = 16'h0000;
  logic [15:0] m_out = 16'h0000;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0;
      m_out   = 16'h0000;
    end else begin
      if (m_phase == 0) begin
        if (in_valid) begin
          m_res   = ref_op(in_data, int'(in_cnt), in_op);
          m_phase = 1;
        end
      end else if (m_phase < 4) begin
        m_phase++;
      end else if (m_phase == 4) begin
        m_phase = 5;
        m_out   = m_res;
      end else if (out_ready) begin
        m_phase = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("cyc_in_ready", {31'd0, in_ready}, {31'd0, m_phase == 0});
      chk("cyc_out_valid", {31'd0, out_valid}, {31'd0, m_phase == 5});
      chk("cyc_busy", {31'd0, busy}, {31'd0, m_phase != 0});
      if (m_phase == 5) chk("cyc_out_data", {16'd0, out_data}, {16'd0, m_out});
    end
  end

  task automatic wait_out_valid(input string name);
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!out_valid) chk({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic run_op(input logic [15:0] d, input logic [3:0] c, input logic [1:0] op,
                        input logic [15:0] exp, input string name);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    in_data  = d;
    in_cnt   = c;
    in_op    = op;
    in_valid = 1'b1;
    n = 0;
    while (n < 12) begin
      @(posedge clk); #1;
      n++;
      if (n == 1) begin
        in_valid = 1'b0;
        in_data  = ~d;
        in_cnt   = ~c;
        in_op    = ~op;
      end
      if (out_valid) break;
    end
    chk({name, "_latency"}, n, 5);
    chk({name, "_data"}, {16'd0, out_data}, {16'd0, exp});
    chk({name, "_model"}, {16'd0, ref_op(d, int'(c), op)}, {16'd0, exp});
    consume();
    chk({name, "_ready_after"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_out_data", {16'd0, out_data}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_op(16'h1234, 4'd8, 2'b10, 16'h3412, "ror8");
    run_op(16'h8001, 4'd1, 2'b00, 16'h0003, "rol1");
    run_op(16'h8001, 4'd15, 2'b10, 16'h0003, "ror15");
    run_op(16'h8000, 4'd15, 2'b11, 16'h0001, "srl15");
    run_op(16'hFFFF, 4'd4, 2'b01, 16'hFFF0, "sll4");
    for (int o = 0; o < 4; o++) run_op(16'hABCD, 4'd0, o[1:0], 16'hABCD, "cnt0");
    run_op(16'h5A5A, 4'd7, 2'b11, 16'h00B4, "srl7");

    // Backpressure with a second request waiting.
    in_data = 16'h5A5A; in_cnt = 4'd3; in_op = 2'b01; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_out_valid("bp_first");
    in_data = 16'h00F0; in_cnt = 4'd4; in_op = 2'b10; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_hold_data", {16'd0, out_data}, 32'h0000D2D0);
      chk("bp_hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_idle_ready", {31'd0, in_ready}, 32'd1);
    chk("bp_idle_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_second_busy", {31'd0, busy}, 32'd1);
    wait_out_valid("bp_second");
    chk("bp_second_data", {16'd0, out_data}, 32'h0000000F);
    consume();

    // Reset dropped in the second shift cycle.
    in_data = 16'h1234; in_cnt = 4'd5; in_op = 2'b00; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_out_data", {16'd0, out_data}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(16'h1234, 4'd5, 2'b00, 16'h4682, "after_rst");

    for (int o = 0; o < 4; o++) begin
      for (int c = 0; c < 16; c++) begin
        logic [15:0] d;
        d = 16'($urandom);
        run_op(d, c[3:0], o[1:0], ref_op(d, c, o[1:0]), "sweep");
      end
    end

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/shift_sequencer.md
# shift_sequencer

Multi-cycle sequencer for a 16-bit rotate/shift datapath. It accepts one operand, a 4-bit amount and an opcode through a valid/ready handshake. It then walks the amount bits MSB-first through binary-weighted stages (8, 4, 2, 1), one stage per clock, applying each stage only when its amount bit is set. The block sits between the decode/execute stage and the writeback mux as the iterative alternative to the fully combinational barrel shifter.

## Interface
- Parameters: none. Data width fixed at 16, amount width fixed at 4.
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low; synchronous deassert supplied externally.
- in_valid  in  1  request present.
- in_ready  out  1  block can accept; high only in IDLE.
- in_data  in  16  operand.
- in_cnt  in  4  shift/rotate amount, 0..15.
- in_op  in  2  opcode:
  - 00 rotate left
  - 01 shift left logical
  - 10 rotate right
  - 11 shift right logical
- out_valid  out  1  result held and valid; high only in DONE.
- out_ready  in  1  consumer takes result.
- out_data  out  16  result register.
- busy  out  1  high in SHIFT or DONE.

## Operation
- State machine IDLE, SHIFT, DONE. Encoding is free.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch in_data→acc, in_cnt→cnt_q, in_op→op_q; stage index ←3; go SHIFT.
  - Inputs are ignored when in_valid=0.
- SHIFT, each cycle:
  - Stage amount k=2^stage.
  - If cnt_q[stage]=1, acc←acc shifted or rotated by k per op_q; otherwise acc unchanged.
  - Stage 0 → DONE; otherwise decrement stage.
- Stage functions on 16 bits, with k in {8,4,2,1}:
  - rotate left: bits leaving bit 15 re-enter at bit 0.
  - rotate right: bits leaving bit 0 re-enter at bit 15.
  - Logical shifts zero-fill vacated bits.
  - Composite result equals the op applied by in_cnt in a single step.
- DONE:
  - out_valid=1, out_data=acc, stable until accepted.
  - On out_ready=1 → IDLE.
  - in_valid is ignored; in_ready=0.
- Every request takes exactly 4 SHIFT cycles, including in_cnt=0 (no early exit), so latency is deterministic.
- Latched fields are never modified by input changes after acceptance.
- Opcode is only decoded from op_q, never from in_op directly.

## Timing
- Reset (rst_n=0, immediate, independent of clk):
  - state=IDLE, in_ready=1, out_valid=0, busy=0, out_data=16'h0000.
  - Internal acc, cnt_q, op_q and stage cleared to 0.
- Acceptance at edge E0 → SHIFT at E1..E4 → out_valid=1 in the cycle after E4. Latency is 5 edges from accept to visible result.
- Result consumed at the first edge with out_valid&out_ready. in_ready returns high the following cycle.
- Minimum initiation interval is 6 cycles. No overlap of consecutive requests.
- out_ready asserted early (before DONE) has no effect. in_valid asserted outside IDLE is neither accepted nor queued.
- Reset asserted mid-SHIFT or in DONE: the operation is dropped and no partial result is ever presented. After deassert, the first accept occurs no earlier than the next edge.
- All outputs are registered or decoded from the state register only. There is no combinational path from in_* or out_ready to any output.

## Test plan
- Rotate right by 8: in_data=16'h1234, in_cnt=8, in_op=10 → out_data=16'h3412, out_valid exactly 5 edges after accept.
- Rotate left by 1 with wrap: 16'h8001, cnt=1, op=00 → 16'h0003. Same operand with cnt=15, op=10 → 16'h0003.
- Logical shifts:
  - 16'h8000, cnt=15, op=11 → 16'h0001.
  - 16'hFFFF, cnt=4, op=01 → 16'hFFF0.
  - 16'hABCD, cnt=0, any op → 16'hABCD, still 4 SHIFT cycles.
- Backpressure:
  - Hold out_ready=0 for 3 cycles in DONE → out_data stable, in_ready=0.
  - A second in_valid during this time is not accepted.
  - out_ready=1 → IDLE next cycle, then the second request is accepted and completes correctly.
- Reset mid-operation: pull rst_n low during the 2nd SHIFT cycle → out_valid=0, in_ready=1, out_data=0 without waiting for clk. The next request after release produces the correct result.
- Randomized sweep: all 4 ops × all 16 counts × random operands, compared against a reference model. No mismatch is permitted.
